tt_matrix_seq: RTL and testbench

TT_MATRIX_SEQ -- requirements
Module: tt_matrix_seq

---
 rtl/tt_matrix_seq.sv | 190 +++++++++++++++++++
 tb/tb_tt_matrix_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_matrix_seq.sv
// Matrix-unit instruction sequencer: decodes OPACC/CIN/COUT, tracks per-register
// accumulate latency, stalls loads/reads on busy registers, and returns load-queue responses.
module tt_matrix_seq #(
   parameter int LQ_DEPTH_LOG2 = 3,
   parameter int VLEN          = 256,
   parameter int NUM_MREGS     = 2,
   parameter int OPACC_LAT     = 3,
   localparam int MSEL_W       = (NUM_MREGS > 1) ? $clog2(NUM_MREGS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_inst_vld,
   input  logic [31:0]              i_inst,
   input  logic [LQ_DEPTH_LOG2-1:0] i_lqid,
   output logic                     o_inst_rdy,
   output logic                     o_ab_valid,
   output logic                     o_ci_valid,
   output logic                     o_co_valid,
   output logic [MSEL_W-1:0]        o_mreg_sel,
   output logic [14:0]              o_vrf_rdaddr,
   input  logic [VLEN-1:0]          i_co_data,
   output logic                     o_mvex_lqvld,
   output logic [VLEN-1:0]          o_mvex_lqdata,
   output logic                     o_mvex_lqexc,
   output logic [LQ_DEPTH_LOG2-1:0] o_mvex_lqid,
   input  logic                     i_mvex_lqrdy
);

   localparam int CNT_W = $clog2(OPACC_LAT + 1);
   localparam logic [6:0] OPC_MATRIX = 7'h0B;
   localparam logic [2:0] F3_OPACC   = 3'd0;
   localparam logic [2:0] F3_CIN     = 3'd1;
   localparam logic [2:0] F3_COUT    = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HAZ,
      ST_COWAIT,
      ST_RESP
   } state_t;

   state_t                   state_reg, state_next;
   logic [31:0]              inst_reg, inst_next;
   logic [LQ_DEPTH_LOG2-1:0] lqid_reg, lqid_next;
   logic [VLEN-1:0]          lqdata_reg, lqdata_next;
   logic                     lqexc_reg, lqexc_next;
   logic [LQ_DEPTH_LOG2-1:0] lqid_out_reg, lqid_out_next;

   logic [CNT_W-1:0]         cnt_reg  [NUM_MREGS];
   logic [CNT_W-1:0]         cnt_next [NUM_MREGS];
   logic [NUM_MREGS-1:0]     opacc_hit;

   logic [31:0]              cur_inst;
   logic [6:0]               opcode;
   logic [4:0]               c_addr, a_addr, b_addr;
   logic [2:0]               funct3;
   logic [MSEL_W-1:0]        sel;
   logic                     c_legal, illegal;
   logic [CNT_W-1:0]         tgt_cnt;
   logic                     ab_pulse, ci_pulse, co_pulse, any_pulse;
   logic                     opacc_load;
   logic                     unused_bits;

   // In HAZ the held instruction drives decode; otherwise the offered one does.
   assign cur_inst = (state_reg == ST_HAZ) ? inst_reg : i_inst;
   assign opcode   = cur_inst[6:0];
   assign c_addr   = cur_inst[11:7];
   assign funct3   = cur_inst[14:12];
   assign a_addr   = cur_inst[19:15];
   assign b_addr   = cur_inst[24:20];
   assign unused_bits = ^cur_inst[31:25];

   assign sel     = c_addr[MSEL_W-1:0];
   assign c_legal = (NUM_MREGS >= 32) || ({1'b0, c_addr} < 6'(NUM_MREGS));
   assign illegal = (opcode != OPC_MATRIX) || (funct3 > F3_COUT) || !c_legal;
   assign tgt_cnt = cnt_reg[sel];

   always_comb begin
      state_next    = state_reg;
      inst_next     = inst_reg;
      lqid_next     = lqid_reg;
      lqdata_next   = lqdata_reg;
      lqexc_next    = lqexc_reg;
      lqid_out_next = lqid_out_reg;
      ab_pulse      = 1'b0;
      ci_pulse      = 1'b0;
      co_pulse      = 1'b0;
      opacc_load    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (i_inst_vld) begin
               inst_next = i_inst;
               lqid_next = i_lqid;
               if (illegal) begin
                  lqdata_next   = '0;
                  lqexc_next    = 1'b1;
                  lqid_out_next = i_lqid;
                  state_next    = ST_RESP;
               end else if (funct3 == F3_OPACC) begin
                  ab_pulse   = 1'b1;
                  opacc_load = 1'b1;
               end else if (tgt_cnt == '0) begin
                  if (funct3 == F3_CIN) begin
                     ci_pulse = 1'b1;
                  end else begin
                     co_pulse   = 1'b1;
                     state_next = ST_COWAIT;
                  end
               end else begin
                  state_next = ST_HAZ;
               end
            end
         end
         ST_HAZ: begin
            if (tgt_cnt == '0) begin
               if (funct3 == F3_CIN) begin
                  ci_pulse   = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  co_pulse   = 1'b1;
                  state_next = ST_COWAIT;
               end
            end
         end
         ST_COWAIT: begin
            lqdata_next   = i_co_data;
            lqexc_next    = 1'b0;
            lqid_out_next = lqid_reg;
            state_next    = ST_RESP;
         end
         ST_RESP: begin
            if (i_mvex_lqrdy) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Busy counters: an OPACC reload takes priority over the countdown.
   generate
      for (genvar gi = 0; gi < NUM_MREGS; gi++) begin : g_cnt
         assign opacc_hit[gi] = opacc_load && (sel == MSEL_W'(gi));
         assign cnt_next[gi]  = opacc_hit[gi]           ? CNT_W'(OPACC_LAT) :
                                (cnt_reg[gi] != '0)     ? cnt_reg[gi] - CNT_W'(1) :
                                                          '0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         inst_reg     <= '0;
         lqid_reg     <= '0;
         lqdata_reg   <= '0;
         lqexc_reg    <= 1'b0;
         lqid_out_reg <= '0;
      end else begin
         state_reg    <= state_next;
         inst_reg     <= inst_next;
         lqid_reg     <= lqid_next;
         lqdata_reg   <= lqdata_next;
         lqexc_reg    <= lqexc_next;
         lqid_out_reg <= lqid_out_next;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_MREGS; i++) begin
         if (reset) begin
            cnt_reg[i] <= '0;
         end else begin
            cnt_reg[i] <= cnt_next[i];
         end
      end
   end

   assign any_pulse     = (ab_pulse | ci_pulse | co_pulse) & ~reset;
   assign o_ab_valid    = ab_pulse & ~reset;
   assign o_ci_valid    = ci_pulse & ~reset;
   assign o_co_valid    = co_pulse & ~reset;
   assign o_mreg_sel    = any_pulse ? sel : '0;
   assign o_vrf_rdaddr  = any_pulse ? {a_addr, b_addr, c_addr} : 15'd0;
   assign o_inst_rdy    = (state_reg == ST_IDLE) & ~reset;
   assign o_mvex_lqvld  = (state_reg == ST_RESP) & ~reset;
   assign o_mvex_lqdata = lqdata_reg;
   assign o_mvex_lqexc  = lqexc_reg;
   assign o_mvex_lqid   = lqid_out_reg;

endmodule

// File: tb/tb_tt_matrix_seq.sv
// Directed bench for tt_matrix_seq: single-instruction vector table plus
// hand-written hazard, back-pressure, reload and reset sequences.
module tb_tt_matrix_seq;

   logic         clk = 1'b0;
   logic         reset;
   logic         i_inst_vld;
   logic [31:0]  i_inst;
   logic [2:0]   i_lqid;
   logic         o_inst_rdy, o_ab_valid, o_ci_valid, o_co_valid;
   logic [0:0]   o_mreg_sel;
   logic [14:0]  o_vrf_rdaddr;
   logic [255:0] i_co_data;
   logic         o_mvex_lqvld;
   logic [255:0] o_mvex_lqdata;
   logic         o_mvex_lqexc;
   logic [2:0]   o_mvex_lqid;
   logic         i_mvex_lqrdy;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [255:0] PAT = {32{8'hA5}};
   localparam logic [255:0] ALT = {32{8'h3C}};

   tt_matrix_seq dut (
      .clk(clk), .reset(reset), .i_inst_vld(i_inst_vld), .i_inst(i_inst), .i_lqid(i_lqid),
      .o_inst_rdy(o_inst_rdy), .o_ab_valid(o_ab_valid), .o_ci_valid(o_ci_valid),
      .o_co_valid(o_co_valid), .o_mreg_sel(o_mreg_sel), .o_vrf_rdaddr(o_vrf_rdaddr),
      .i_co_data(i_co_data), .o_mvex_lqvld(o_mvex_lqvld), .o_mvex_lqdata(o_mvex_lqdata),
      .o_mvex_lqexc(o_mvex_lqexc), .o_mvex_lqid(o_mvex_lqid), .i_mvex_lqrdy(i_mvex_lqrdy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [2:0]  lqid;
      logic        ab, ci, co;
      logic [0:0]  sel;
      logic [14:0] addr;
      int          resp;    // 0 none, 1 exception, 2 read data
   } vec_t;

   vec_t vecs[8];

   function automatic logic [31:0] mk(input logic [4:0] a, input logic [4:0] b,
                                      input logic [2:0] f3, input logic [4:0] c,
                                      input logic [6:0] op);
      return {7'd0, b, a, f3, c, op};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_inst_vld = 1'b0;
      i_mvex_lqrdy = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic no_pulse(input string name);
      chk(name, {253'd0, o_ab_valid, o_ci_valid, o_co_valid}, 256'd0);
   endtask

   int stalls;
   bit got;
   logic [1:0] exp_cnt [4];

   initial begin
      reset = 1'b1; i_inst_vld = 1'b0; i_inst = '0; i_lqid = '0;
      i_co_data = ALT; i_mvex_lqrdy = 1'b0;

      //          inst                          lqid ab ci co sel addr                    resp
      vecs[0] = '{mk(5'd3, 5'd4, 3'd0, 5'd1, 7'h0B), 3'd1, 1, 0, 0, 1'b1, {5'd3, 5'd4, 5'd1}, 0};
      vecs[1] = '{mk(5'd31, 5'd0, 3'd0, 5'd0, 7'h0B), 3'd0, 1, 0, 0, 1'b0, {5'd31, 5'd0, 5'd0}, 0};
      vecs[2] = '{mk(5'd2, 5'd5, 3'd1, 5'd1, 7'h0B), 3'd3, 0, 1, 0, 1'b1, {5'd2, 5'd5, 5'd1}, 0};
      vecs[3] = '{mk(5'd7, 5'd9, 3'd2, 5'd0, 7'h0B), 3'd6, 0, 0, 1, 1'b0, {5'd7, 5'd9, 5'd0}, 2};
      vecs[4] = '{mk(5'd1, 5'd1, 3'd0, 5'd0, 7'h33), 3'd2, 0, 0, 0, 1'b0, 15'd0, 1};
      vecs[5] = '{mk(5'd4, 5'd6, 3'd2, 5'd3, 7'h0B), 3'd4, 0, 0, 0, 1'b0, 15'd0, 1};
      vecs[6] = '{mk(5'd4, 5'd6, 3'd3, 5'd0, 7'h0B), 3'd7, 0, 0, 0, 1'b0, 15'd0, 1};
      vecs[7] = '{mk(5'd8, 5'd2, 3'd1, 5'd2, 7'h0B), 3'd5, 0, 0, 0, 1'b0, 15'd0, 1};

      // Reset state
      step();
      #1;
      chk("rdy_in_reset", {255'd0, o_inst_rdy}, 256'd0);
      do_reset();
      #1;
      chk("rdy_after_reset", {255'd0, o_inst_rdy}, 256'd1);
      chk("lqvld_after_reset", {255'd0, o_mvex_lqvld}, 256'd0);
      chk("cnt0_after_reset", {254'd0, dut.cnt_reg[0]}, 256'd0);

      foreach (vecs[v]) begin
         do_reset();
         i_inst_vld = 1'b1; i_inst = vecs[v].inst; i_lqid = vecs[v].lqid;
         #1;
         $display("vec %0d inst=%h lqid=%0d ab=%b ci=%b co=%b sel=%b addr=%h",
                  v, vecs[v].inst, vecs[v].lqid, o_ab_valid, o_ci_valid, o_co_valid,
                  o_mreg_sel, o_vrf_rdaddr);
         chk($sformatf("v%0d_rdy", v), {255'd0, o_inst_rdy}, 256'd1);
         chk($sformatf("v%0d_ab", v), {255'd0, o_ab_valid}, {255'd0, vecs[v].ab});
         chk($sformatf("v%0d_ci", v), {255'd0, o_ci_valid}, {255'd0, vecs[v].ci});
         chk($sformatf("v%0d_co", v), {255'd0, o_co_valid}, {255'd0, vecs[v].co});
         chk($sformatf("v%0d_sel", v), {255'd0, o_mreg_sel}, {255'd0, vecs[v].sel});
         chk($sformatf("v%0d_addr", v), {241'd0, o_vrf_rdaddr}, {241'd0, vecs[v].addr});
         step();
         i_inst_vld = 1'b0; i_inst = '0;
         if (vecs[v].resp == 2) begin
            i_co_data = PAT;
            #1;
            chk($sformatf("v%0d_cowait_lqvld", v), {255'd0, o_mvex_lqvld}, 256'd0);
            step();
            i_co_data = ALT;
         end
         if (vecs[v].resp != 0) begin
            #1;
            chk($sformatf("v%0d_lqvld", v), {255'd0, o_mvex_lqvld}, 256'd1);
            chk($sformatf("v%0d_lqexc", v), {255'd0, o_mvex_lqexc},
                (vecs[v].resp == 1) ? 256'd1 : 256'd0);
            chk($sformatf("v%0d_lqdata", v), o_mvex_lqdata,
                (vecs[v].resp == 1) ? 256'd0 : PAT);
            chk($sformatf("v%0d_lqid", v), {253'd0, o_mvex_lqid}, {253'd0, vecs[v].lqid});
            chk($sformatf("v%0d_resp_rdy", v), {255'd0, o_inst_rdy}, 256'd0);
            i_mvex_lqrdy = 1'b1;
            step();
            i_mvex_lqrdy = 1'b0;
         end
         #1;
         chk($sformatf("v%0d_end_lqvld", v), {255'd0, o_mvex_lqvld}, 256'd0);
         chk($sformatf("v%0d_end_rdy", v), {255'd0, o_inst_rdy}, 256'd1);
      end

      // OPACC c=1: counter runs 3,2,1,0
      do_reset();
      i_inst_vld = 1'b1; i_inst = mk(5'd0, 5'd0, 3'd0, 5'd1, 7'h0B);
      #1;
      chk("cnt_seq_ab", {255'd0, o_ab_valid}, 256'd1);
      step();
      i_inst_vld = 1'b0;
      exp_cnt = '{2'd3, 2'd2, 2'd1, 2'd0};
      for (int k = 0; k < 4; k++) begin
         #1;
         $display("cnt_seq k=%0d cnt1=%0d", k, dut.cnt_reg[1]);
         chk($sformatf("cnt1_k%0d", k), {254'd0, dut.cnt_reg[1]}, {254'd0, exp_cnt[k]});
         step();
      end

      // OPACC c=0 then COUT c=0 lqid=5: hazard stall, then read with back-pressure
      do_reset();
      i_inst_vld = 1'b1; i_inst = mk(5'd1, 5'd2, 3'd0, 5'd0, 7'h0B); i_lqid = 3'd1;
      #1;
      chk("haz_opacc_ab", {255'd0, o_ab_valid}, 256'd1);
      step();
      i_inst = mk(5'd3, 5'd4, 3'd2, 5'd0, 7'h0B); i_lqid = 3'd5;
      #1;
      chk("haz_cout_nopulse", {255'd0, o_co_valid}, 256'd0);
      chk("haz_cout_accept", {255'd0, o_inst_rdy}, 256'd1);
      step();
      i_inst_vld = 1'b0; i_inst = '0; i_lqid = '0;
      stalls = 0; got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         #1;
         if (o_co_valid) begin
            got = 1'b1;
            chk("haz_co_sel", {255'd0, o_mreg_sel}, 256'd0);
            chk("haz_co_addr", {241'd0, o_vrf_rdaddr}, {241'd0, 5'd3, 5'd4, 5'd0});
         end else begin
            stalls++;
            chk($sformatf("haz_stall%0d_rdy", k), {255'd0, o_inst_rdy}, 256'd0);
            no_pulse($sformatf("haz_stall%0d_pulse", k));
         end
         step();
      end
      $display("hazard cout stalls=%0d issued=%0d", stalls, got);
      chk("haz_co_issued", {255'd0, got}, 256'd1);
      chk("haz_stalls", 256'(stalls), 256'd2);
      i_co_data = PAT;
      #1;
      chk("haz_cowait_lqvld", {255'd0, o_mvex_lqvld}, 256'd0);
      step();
      i_co_data = ALT;
      for (int k = 0; k < 4; k++) begin
         #1;
         $display("bp k=%0d lqvld=%b id=%0d data=%h", k, o_mvex_lqvld, o_mvex_lqid,
                  o_mvex_lqdata[31:0]);
         chk($sformatf("bp%0d_lqvld", k), {255'd0, o_mvex_lqvld}, 256'd1);
         chk($sformatf("bp%0d_data", k), o_mvex_lqdata, PAT);
         chk($sformatf("bp%0d_id", k), {253'd0, o_mvex_lqid}, 256'd5);
         chk($sformatf("bp%0d_exc", k), {255'd0, o_mvex_lqexc}, 256'd0);
         chk($sformatf("bp%0d_rdy", k), {255'd0, o_inst_rdy}, 256'd0);
         step();
      end
      i_mvex_lqrdy = 1'b1;
      #1;
      chk("bp_hs_rdy", {255'd0, o_inst_rdy}, 256'd0);
      step();
      i_mvex_lqrdy = 1'b0;
      #1;
      chk("bp_idle_rdy", {255'd0, o_inst_rdy}, 256'd1);
      chk("bp_idle_lqvld", {255'd0, o_mvex_lqvld}, 256'd0);

      // OPACC reload while counter is 1
      do_reset();
      i_inst_vld = 1'b1; i_inst = mk(5'd0, 5'd0, 3'd0, 5'd0, 7'h0B);
      step();
      i_inst_vld = 1'b0;
      step();
      step();
      #1;
      chk("reload_pre_cnt", {254'd0, dut.cnt_reg[0]}, 256'd1);
      i_inst_vld = 1'b1;
      #1;
      chk("reload_ab", {255'd0, o_ab_valid}, 256'd1);
      step();
      i_inst_vld = 1'b0;
      #1;
      $display("reload cnt0=%0d", dut.cnt_reg[0]);
      chk("reload_cnt", {254'd0, dut.cnt_reg[0]}, 256'd3);

      // Reset while in HAZ
      do_reset();
      i_inst_vld = 1'b1; i_inst = mk(5'd0, 5'd0, 3'd0, 5'd1, 7'h0B);
      step();
      i_inst = mk(5'd0, 5'd0, 3'd1, 5'd1, 7'h0B);
      #1;
      chk("rsthaz_ci_held", {255'd0, o_ci_valid}, 256'd0);
      step();
      i_inst_vld = 1'b0;
      #1;
      chk("rsthaz_in_haz", {255'd0, o_inst_rdy}, 256'd0);
      reset = 1'b1;
      #1;
      chk("rsthaz_rdy_during", {255'd0, o_inst_rdy}, 256'd0);
      step();
      reset = 1'b0;
      #1;
      $display("reset in HAZ: rdy=%b cnt1=%0d", o_inst_rdy, dut.cnt_reg[1]);
      chk("rsthaz_rdy", {255'd0, o_inst_rdy}, 256'd1);
      chk("rsthaz_cnt1", {254'd0, dut.cnt_reg[1]}, 256'd0);
      chk("rsthaz_lqvld", {255'd0, o_mvex_lqvld}, 256'd0);
      for (int k = 0; k < 5; k++) begin
         step();
         #1;
         no_pulse($sformatf("rsthaz_after%0d", k));
      end

      // Reset while in RESP
      step();
      i_inst_vld = 1'b1; i_inst = mk(5'd0, 5'd0, 3'd0, 5'd0, 7'h33); i_lqid = 3'd3;
      step();
      i_inst_vld = 1'b0;
      #1;
      chk("rstresp_lqvld_pre", {255'd0, o_mvex_lqvld}, 256'd1);
      chk("rstresp_id_pre", {253'd0, o_mvex_lqid}, 256'd3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      $display("reset in RESP: lqvld=%b exc=%b id=%0d", o_mvex_lqvld, o_mvex_lqexc, o_mvex_lqid);
      chk("rstresp_lqvld", {255'd0, o_mvex_lqvld}, 256'd0);
      chk("rstresp_exc", {255'd0, o_mvex_lqexc}, 256'd0);
      chk("rstresp_id", {253'd0, o_mvex_lqid}, 256'd0);
      chk("rstresp_data", o_mvex_lqdata, 256'd0);
      chk("rstresp_rdy", {255'd0, o_inst_rdy}, 256'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
